// File: rtl/jtpopeye_vtimer_pkg.sv
// Shared geometry defaults and flag types for the Popeye video timer.
// The DMA and object blocks import these so there is one 384x264 definition.
package jtpopeye_vtimer_pkg;

    localparam int DEF_HW       = 9;
    localparam int DEF_VW       = 9;
    localparam int DEF_HTOTAL   = 384;
    localparam int DEF_HB_START = 256;
    localparam int DEF_HB_END   = 0;
    localparam int DEF_HS_START = 288;
    localparam int DEF_HS_END   = 320;
    localparam int DEF_VTOTAL   = 264;
    localparam int DEF_VB_START = 240;
    localparam int DEF_VB_END   = 16;
    localparam int DEF_VS_START = 248;
    localparam int DEF_VS_END   = 251;

    typedef struct packed {
        logic hb;
        logic hs;
        logic vb;
        logic vs;
    } vt_flags_t;

    // Window decode on plain integers, used to derive the reset-time flag values
    function automatic logic win_f(input int c, input int s, input int e);
        logic active;
        if (s < e) begin
            active = (c >= s) && (c < e);
        end else if (s > e) begin
            active = (c >= s) || (c < e);
        end else begin
            active = 1'b0;
        end
        return active;
    endfunction

endpackage

// File: rtl/jtpopeye_vtimer_win.sv
// Counter window decoder: active for S<=c<E, or wrapping through zero when S>E.
module jtpopeye_vtimer_win #(
    parameter int W = 9
) (
    input  logic [W-1:0] c,
    input  logic [W-1:0] S,
    input  logic [W-1:0] E,
    output logic         active
);

    // Equal start and end describes an empty window
    always_comb begin
        if (S < E) begin
            active = (c >= S) && (c < E);
        end else if (S > E) begin
            active = (c >= S) || (c < E);
        end else begin
            active = 1'b0;
        end
    end

endmodule

// File: rtl/jtpopeye_vtimer.sv
// Parametrised H/V timing generator with blanking, syncs, interlace field and
// a flip that only changes at frame start.
module jtpopeye_vtimer
    import jtpopeye_vtimer_pkg::*;
#(
    parameter int HW        = DEF_HW,
    parameter int VW        = DEF_VW,
    parameter int HTOTAL    = DEF_HTOTAL,
    parameter int HB_START  = DEF_HB_START,
    parameter int HB_END    = DEF_HB_END,
    parameter int HS_START  = DEF_HS_START,
    parameter int HS_END    = DEF_HS_END,
    parameter int VTOTAL    = DEF_VTOTAL,
    parameter int VB_START  = DEF_VB_START,
    parameter int VB_END    = DEF_VB_END,
    parameter int VS_START  = DEF_VS_START,
    parameter int VS_END    = DEF_VS_END,
    parameter int INTERLACE = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pxl_cen,
    input  logic          flip_req,
    output logic [HW-1:0] H,
    output logic [VW-1:0] V,
    output logic [HW-1:0] Hf,
    output logic [VW-1:0] Vf,
    output logic          flip,
    output logic          HB,
    output logic          VB,
    output logic          LHBL,
    output logic          LVBL,
    output logic          HS,
    output logic          VS,
    output logic          hinit,
    output logic          vinit,
    output logic          field
);

    localparam logic [HW-1:0] H_LAST = HW'(HTOTAL - 1);
    localparam logic [HW-1:0] H_HALF = HW'(HTOTAL / 2);
    localparam logic [VW-1:0] V_LAST = VW'(VTOTAL - 1);

    // Flags presented together with H=0, V=0 while reset is held
    localparam vt_flags_t RST_FLAGS = {
        win_f(0, HB_START, HB_END),
        win_f(0, HS_START, HS_END),
        win_f(0, VB_START, VB_END),
        win_f(0, VS_START, VS_END)
    };

    if ((HTOTAL > (2 ** HW)) || (VTOTAL > (2 ** VW))) begin : g_bad_total
        $error("jtpopeye_vtimer: HTOTAL/VTOTAL exceed counter width");
    end
    if ((HB_START >= HTOTAL) || (HB_END >= HTOTAL) || (HS_START >= HTOTAL) ||
        (HS_END >= HTOTAL) || (VB_START >= VTOTAL) || (VB_END >= VTOTAL) ||
        (VS_START >= VTOTAL) || (VS_END >= VTOTAL)) begin : g_bad_window
        $error("jtpopeye_vtimer: window edge outside its counter range");
    end

    logic [HW-1:0] h_r;
    logic [VW-1:0] v_r;
    logic          field_r;
    logic          flip_r;
    logic          hinit_r;
    logic          vinit_r;
    vt_flags_t     flags_r;

    logic [HW-1:0] h_nxt_s;
    logic [VW-1:0] v_nxt_s;
    logic          field_nxt_s;
    logic [VW-1:0] vh_s;
    logic          hb_s;
    logic          hs_s;
    logic          vb_s;
    logic          vs_full_s;
    logic          vs_half_s;
    logic          vs_s;
    logic          frame_start_s;

    // Next counter state, shared by the counter load and the flag decoders
    always_comb begin
        v_nxt_s     = v_r;
        field_nxt_s = field_r;
        if (h_r == H_LAST) begin
            h_nxt_s = '0;
            if (v_r == V_LAST) begin
                v_nxt_s     = '0;
                field_nxt_s = (INTERLACE != 0) ? ~field_r : 1'b0;
            end else begin
                v_nxt_s = v_r + VW'(1);
            end
        end else begin
            h_nxt_s = h_r + HW'(1);
        end
    end

    // Line index that changes at mid-line, so field-1 VS edges land on H=HTOTAL/2
    always_comb begin
        if (h_nxt_s >= H_HALF) begin
            vh_s = v_nxt_s;
        end else if (v_nxt_s == '0) begin
            vh_s = V_LAST;
        end else begin
            vh_s = v_nxt_s - VW'(1);
        end
    end

    jtpopeye_vtimer_win #(.W(HW)) u_hb (
        .c(h_nxt_s), .S(HW'(HB_START)), .E(HW'(HB_END)), .active(hb_s)
    );
    jtpopeye_vtimer_win #(.W(HW)) u_hs (
        .c(h_nxt_s), .S(HW'(HS_START)), .E(HW'(HS_END)), .active(hs_s)
    );
    jtpopeye_vtimer_win #(.W(VW)) u_vb (
        .c(v_nxt_s), .S(VW'(VB_START)), .E(VW'(VB_END)), .active(vb_s)
    );
    jtpopeye_vtimer_win #(.W(VW)) u_vs_full (
        .c(v_nxt_s), .S(VW'(VS_START)), .E(VW'(VS_END)), .active(vs_full_s)
    );
    jtpopeye_vtimer_win #(.W(VW)) u_vs_half (
        .c(vh_s), .S(VW'(VS_START)), .E(VW'(VS_END)), .active(vs_half_s)
    );

    // Field 1 of an interlaced picture uses the half-line shifted sync
    always_comb begin
        if ((INTERLACE != 0) && field_nxt_s) begin
            vs_s = vs_half_s;
        end else begin
            vs_s = vs_full_s;
        end
    end

    assign frame_start_s = (h_nxt_s == '0) && (v_nxt_s == '0);

    // Counters and pre-decoded flags advance together on each pixel enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_r     <= '0;
            v_r     <= '0;
            field_r <= 1'b0;
            flip_r  <= 1'b0;
            hinit_r <= 1'b1;
            vinit_r <= 1'b1;
            flags_r <= RST_FLAGS;
        end else if (pxl_cen) begin
            h_r     <= h_nxt_s;
            v_r     <= v_nxt_s;
            field_r <= field_nxt_s;
            hinit_r <= (h_nxt_s == '0);
            vinit_r <= frame_start_s;
            flags_r <= {hb_s, hs_s, vb_s, vs_s};
            if (frame_start_s) begin
                flip_r <= flip_req;
            end
        end
    end

    assign H     = h_r;
    assign V     = v_r;
    assign Hf    = h_r ^ {HW{flip_r}};
    assign Vf    = v_r ^ {VW{flip_r}};
    assign flip  = flip_r;
    assign HB    = flags_r.hb;
    assign HS    = flags_r.hs;
    assign VB    = flags_r.vb;
    assign VS    = flags_r.vs;
    assign LHBL  = ~flags_r.hb;
    assign LVBL  = ~flags_r.vb;
    assign hinit = hinit_r;
    assign vinit = vinit_r;
    assign field = field_r;

endmodule

// File: tb/tb_jtpopeye_vtimer.sv
// Bench for jtpopeye_vtimer: default, wrapped-HB, and small-geometry (plain and
// interlaced) instances run in lockstep against a scoreboard-fed model.
`timescale 1ns/1ps
module tb_jtpopeye_vtimer;

    typedef struct packed {
        logic [8:0] h, v, hf, vf;
        logic flip, hb, vb, lhbl, lvbl, hs, vs, hinit, vinit, field;
    } obs_t;
    typedef struct packed { obs_t d, w, s, i; } exp_t;
    typedef struct {
        int         ncen;
        logic [8:0] h, v;
        logic       hb, hs, vb, vs, hinit, vinit, hbw;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pxl_cen = 1'b0;
    logic flip_req = 1'b0;
    always #5 clk = ~clk;

    logic [8:0] d_h, d_v, d_hf, d_vf, w_h, w_v, w_hf, w_vf;
    logic [8:0] s_h, s_v, s_hf, s_vf, i_h, i_v, i_hf, i_vf;
    logic d_flip, d_hb, d_vb, d_lhbl, d_lvbl, d_hs, d_vs, d_hinit, d_vinit, d_field;
    logic w_flip, w_hb, w_vb, w_lhbl, w_lvbl, w_hs, w_vs, w_hinit, w_vinit, w_field;
    logic s_flip, s_hb, s_vb, s_lhbl, s_lvbl, s_hs, s_vs, s_hinit, s_vinit, s_field;
    logic i_flip, i_hb, i_vb, i_lhbl, i_lvbl, i_hs, i_vs, i_hinit, i_vinit, i_field;
    obs_t act_d, act_w, act_s, act_i;

    jtpopeye_vtimer dut_d (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .flip_req(flip_req),
        .H(d_h), .V(d_v), .Hf(d_hf), .Vf(d_vf), .flip(d_flip), .HB(d_hb), .VB(d_vb),
        .LHBL(d_lhbl), .LVBL(d_lvbl), .HS(d_hs), .VS(d_vs), .hinit(d_hinit),
        .vinit(d_vinit), .field(d_field)
    );
    jtpopeye_vtimer #(.HB_START(300), .HB_END(20)) dut_w (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .flip_req(flip_req),
        .H(w_h), .V(w_v), .Hf(w_hf), .Vf(w_vf), .flip(w_flip), .HB(w_hb), .VB(w_vb),
        .LHBL(w_lhbl), .LVBL(w_lvbl), .HS(w_hs), .VS(w_vs), .hinit(w_hinit),
        .vinit(w_vinit), .field(w_field)
    );
    jtpopeye_vtimer #(.HTOTAL(24), .HB_START(16), .HB_END(0), .HS_START(18), .HS_END(20),
        .VTOTAL(20), .VB_START(15), .VB_END(2), .VS_START(16), .VS_END(18)) dut_s (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .flip_req(flip_req),
        .H(s_h), .V(s_v), .Hf(s_hf), .Vf(s_vf), .flip(s_flip), .HB(s_hb), .VB(s_vb),
        .LHBL(s_lhbl), .LVBL(s_lvbl), .HS(s_hs), .VS(s_vs), .hinit(s_hinit),
        .vinit(s_vinit), .field(s_field)
    );
    jtpopeye_vtimer #(.HTOTAL(24), .HB_START(16), .HB_END(0), .HS_START(18), .HS_END(20),
        .VTOTAL(20), .VB_START(15), .VB_END(2), .VS_START(16), .VS_END(18),
        .INTERLACE(1)) dut_i (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .flip_req(flip_req),
        .H(i_h), .V(i_v), .Hf(i_hf), .Vf(i_vf), .flip(i_flip), .HB(i_hb), .VB(i_vb),
        .LHBL(i_lhbl), .LVBL(i_lvbl), .HS(i_hs), .VS(i_vs), .hinit(i_hinit),
        .vinit(i_vinit), .field(i_field)
    );

    assign act_d = {d_h, d_v, d_hf, d_vf, d_flip, d_hb, d_vb, d_lhbl, d_lvbl, d_hs, d_vs, d_hinit, d_vinit, d_field};
    assign act_w = {w_h, w_v, w_hf, w_vf, w_flip, w_hb, w_vb, w_lhbl, w_lvbl, w_hs, w_vs, w_hinit, w_vinit, w_field};
    assign act_s = {s_h, s_v, s_hf, s_vf, s_flip, s_hb, s_vb, s_lhbl, s_lvbl, s_hs, s_vs, s_hinit, s_vinit, s_field};
    assign act_i = {i_h, i_v, i_hf, i_vf, i_flip, i_hb, i_vb, i_lhbl, i_lvbl, i_hs, i_vs, i_hinit, i_vinit, i_field};

    int n_pass = 0;
    int n_total = 0;

    // Reference state: default geometry (d, w) and small geometry (s, i)
    int   mh, mv, sh, sv;
    logic mflip, sflip, sfi;
    exp_t sbq[$];

    function automatic logic win(input int c, input int s, input int e);
        if (s < e) return (c >= s) && (c < e);
        else if (s > e) return (c >= s) || (c < e);
        else return 1'b0;
    endfunction

    // Field-1 VS is a window over the linear pixel position, shifted by half a line
    function automatic obs_t mk(input int h, input int v, input logic fld, input logic flp,
                                input int ht, input int hbs, input int hbe, input int hss,
                                input int hse, input int vt, input int vbs, input int vbe,
                                input int vss, input int vse, input bit il);
        obs_t o;
        o.h     = 9'(h);
        o.v     = 9'(v);
        o.hf    = 9'(h) ^ {9{flp}};
        o.vf    = 9'(v) ^ {9{flp}};
        o.flip  = flp;
        o.hb    = win(h, hbs, hbe);
        o.vb    = win(v, vbs, vbe);
        o.lhbl  = ~o.hb;
        o.lvbl  = ~o.vb;
        o.hs    = win(h, hss, hse);
        if (il && fld) o.vs = win(v * ht + h, vss * ht + ht / 2, vse * ht + ht / 2);
        else           o.vs = win(v, vss, vse);
        o.hinit = (h == 0);
        o.vinit = (h == 0) && (v == 0);
        o.field = il ? fld : 1'b0;
        return o;
    endfunction

    function automatic exp_t expected();
        exp_t e;
        e.d = mk(mh, mv, 1'b0, mflip, 384, 256, 0, 288, 320, 264, 240, 16, 248, 251, 1'b0);
        e.w = mk(mh, mv, 1'b0, mflip, 384, 300, 20, 288, 320, 264, 240, 16, 248, 251, 1'b0);
        e.s = mk(sh, sv, 1'b0, sflip, 24, 16, 0, 18, 20, 20, 15, 2, 16, 18, 1'b0);
        e.i = mk(sh, sv, sfi, sflip, 24, 16, 0, 18, 20, 20, 15, 2, 16, 18, 1'b1);
        return e;
    endfunction

    task automatic model_reset();
        mh = 0; mv = 0; sh = 0; sv = 0; mflip = 1'b0; sflip = 1'b0; sfi = 1'b0;
    endtask

    task automatic model_cen();
        mh = mh + 1;
        if (mh == 384) begin mh = 0; mv = (mv == 263) ? 0 : mv + 1; end
        if (mh == 0 && mv == 0) mflip = flip_req;
        sh = sh + 1;
        if (sh == 24) begin
            sh = 0;
            if (sv == 19) begin sv = 0; sfi = ~sfi; end
            else sv = sv + 1;
        end
        if (sh == 0 && sv == 0) sflip = flip_req;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic sb_check();
        exp_t e;
        if (sbq.size() == 0) begin
            n_total++;
            $display("FAIL sb_empty: got no expected entry, required one (t=%0t)", $time);
        end else begin
            e = sbq.pop_front();
            chk("sb_d", act_d, e.d);
            chk("sb_w", act_w, e.w);
            chk("sb_s", act_s, e.s);
            chk("sb_i", act_i, e.i);
        end
    endtask

    task automatic tick(input logic cen);
        pxl_cen = cen;
        if (cen && !rst) model_cen();
        sbq.push_back(expected());
        @(posedge clk);
        #1;
        sb_check();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick(1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        sbq.push_back(expected());
        #2;
        sb_check();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation still running at %0t, required finish", $time);
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vt[13];
        int   nh, nv;
        // ncen, H, V, HB, HS, VB, VS, hinit, vinit, HB(wrap instance)
        vt[0]  = '{0,   9'd0,   9'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        vt[1]  = '{1,   9'd1,   9'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[2]  = '{18,  9'd19,  9'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[3]  = '{1,   9'd20,  9'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[4]  = '{235, 9'd255, 9'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[5]  = '{1,   9'd256, 9'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[6]  = '{32,  9'd288, 9'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[7]  = '{11,  9'd299, 9'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[8]  = '{1,   9'd300, 9'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[9]  = '{19,  9'd319, 9'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[10] = '{1,   9'd320, 9'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[11] = '{63,  9'd383, 9'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[12] = '{1,   9'd0,   9'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        model_reset();
        #12;
        sbq.push_back(expected());
        sb_check();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // One line of the default geometry, with the wrapped-HB instance alongside
        for (int r = 0; r < 13; r++) begin
            run(vt[r].ncen);
            chk($sformatf("vec%0d", r),
                {39'd0, d_h, d_v, d_hb, d_hs, d_vb, d_vs, d_hinit, d_vinit, w_hb},
                {39'd0, vt[r].h, vt[r].v, vt[r].hb, vt[r].hs, vt[r].vb, vt[r].vs,
                 vt[r].hinit, vt[r].vinit, vt[r].hbw});
        end

        // Whole small frame: strobe counts per frame
        do_reset();
        nh = 0; nv = 0;
        for (int k = 0; k < 480; k++) begin
            tick(1'b1);
            nh += int'(s_hinit);
            nv += int'(s_vinit);
        end
        chk("s_hinit_cnt", 64'(nh), 64'd20);
        chk("s_vinit_cnt", 64'(nv), 64'd1);
        chk("i_field1", 64'(i_field), 64'd1);

        // Field 1 VS edges at mid-line of VS_START and VS_END
        run(395);
        chk("i_vs_16_11", {63'd0, i_vs}, 64'd0);
        chk("s_vs_16_11", {63'd0, s_vs}, 64'd1);
        run(1);
        chk("i_vs_16_12", {63'd0, i_vs}, 64'd1);
        run(47);
        chk("i_vs_18_11", {63'd0, i_vs}, 64'd1);
        chk("s_vs_18_11", {63'd0, s_vs}, 64'd0);
        run(1);
        chk("i_vs_18_12", {63'd0, i_vs}, 64'd0);
        run(36);
        chk("i_field0", {63'd0, i_field}, 64'd0);

        // Flip requested mid-frame takes effect only at the next frame start
        run(240);
        flip_req = 1'b1;
        run(239);
        chk("s_flip_hold", {63'd0, s_flip}, 64'd0);
        run(1);
        chk("s_flip_set", {62'd0, s_flip, s_vinit}, 64'd3);
        run(5);
        chk("s_hf5", {55'd0, s_hf}, 64'h1FA);
        chk("s_vf0", {55'd0, s_vf}, 64'h1FF);
        flip_req = 1'b0;
        run(10);
        chk("s_flip_keep", {63'd0, s_flip}, 64'd1);

        // No pixel enable: nothing may move
        for (int k = 0; k < 100; k++) tick(1'b0);

        // Reset asserted mid-line on the default geometry
        do_reset();
        run(50 * 384 + 200);
        chk("d_pos", {46'd0, d_h, d_v}, {46'd0, 9'd200, 9'd50});
        #2;
        rst = 1'b1;
        model_reset();
        sbq.push_back(expected());
        #1;
        sb_check();
        chk("rst_clear", {44'd0, d_h, d_v, d_vb, d_flip}, {44'd0, 9'd0, 9'd0, 1'b1, 1'b0});
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(1'b1);
        chk("rst_first_h", {55'd0, d_h}, 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
